ram_io_responder: RTL and testbench
===================================

RAM_IO_RESPONDER -- requirements
Module: ram_io_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 17: RAM byte-address width, giving a RAM of 2^ADDR_W bytes.
REQ-002 SHALL have parameter TXQ_LOG, default 3: TX queue depth is 2^TXQ_LOG bytes.
REQ-003 SHALL have parameter FULL_MARGIN, default 2: the number of free TX slots at or below which io_buffer_full is raised.
REQ-004 SHALL have the following ports, clock and reset first; reset rst is synchronous and active-high, and the clock is clk:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- mem_a  in  32  byte address from the controller; only bits 17:0 are decoded
- mem_dout  in  8  write data from the controller
- mem_wr  in  1  1 = write, 0 = read
- mem_din  out  8  registered read data to the controller
- io_buffer_full  out  1  TX queue nearly full
- tx_data  out  8  TX queue head byte
- tx_valid  out  1  TX queue non-empty
- tx_ready  in  1  consumer accepts the head byte
- rx_data  in  8  input byte
- rx_valid  in  1  rx_data is valid
- rx_ready  out  1  rx byte is consumed this cycle
- prog_end  out  1  sticky program-end flag
- tx_overflow  out  1  sticky flag: a TX byte was dropped

Function
REQ-005 Address decode SHALL be: IO when mem_a[17:16]==2'b11; RAM otherwise, indexed by mem_a[ADDR_W-1:0].
REQ-006 RAM read: mem_din SHALL equal the RAM byte at the address presented in the previous cycle (1-cycle latency).
REQ-007 RAM write: when mem_wr=1 on a RAM address, mem_dout SHALL be stored at the posedge; mem_din that next cycle SHALL be 8'h00.
REQ-008 A read of a byte written in the immediately preceding cycle SHALL return the new data.
REQ-009 An IO write to 0x30000 SHALL push mem_dout into the TX queue when it is not full; when the queue is full the byte SHALL be dropped and tx_overflow set.
REQ-010 An IO write to 0x30004 SHALL set prog_end; other IO write addresses SHALL be ignored.
REQ-011 IO reads other than 0x30000 SHALL return 8'h00 the next cycle.
REQ-012 The TX queue SHALL be a FIFO: tx_data is the head; a pop occurs when tx_valid && tx_ready.
REQ-013 A push and a pop in the same cycle SHALL leave the count unchanged; a push to a full queue is allowed when a pop occurs in that same cycle.
REQ-014 Read and write pointers SHALL wrap modulo 2^TXQ_LOG; the count SHALL be TXQ_LOG+1 bits wide.
REQ-015 io_buffer_full SHALL be a registered output, equal to 1 when the next-state count >= 2^TXQ_LOG - FULL_MARGIN.
REQ-016 prog_end and tx_overflow SHALL stay at 1 until reset.
REQ-017 The block SHALL never stall the controller; every cycle is an independent access.

Reset
REQ-018 On rst, at the clock edge: mem_din=0, io_buffer_full=0, tx_valid=0, rx_ready=0, prog_end=0, tx_overflow=0, and TX pointers and count = 0.
REQ-019 RAM contents SHALL NOT be cleared by reset.
REQ-020 A reset asserted mid-access SHALL discard that access: no RAM write and no queue push.

Configuration
REQ-021 Macro RAM_IO_RX_EN SHALL control the input path.
REQ-022 With RAM_IO_RX_EN defined, an IO read of 0x30000 SHALL:
- return rx_data on mem_din the next cycle if rx_valid=1, and pulse rx_ready for 1 cycle in the request cycle;
- return 8'h00 with no rx_ready pulse if rx_valid=0.
REQ-023 Without RAM_IO_RX_EN, rx_ready SHALL be tied to 0, rx_data and rx_valid SHALL be ignored, and an IO read of 0x30000 SHALL return 8'h00.

Verification
REQ-024 Write 0xA5 to 0x00010, then read 0x00010 in the next cycle -> mem_din=0xA5 one cycle later.
REQ-025 With TXQ_LOG=3, FULL_MARGIN=2 and tx_ready=0, write bytes 0x41..0x48 to 0x30000 -> io_buffer_full rises after the 6th push; 8 entries held; a 9th write sets tx_overflow.
REQ-026 Queue full, tx_ready=1, and a write of 0x5A in the same cycle -> count stays 8, head advances, and 0x5A is accepted without overflow.
REQ-027 Write to 0x30004 -> prog_end=1 and remains 1 across further traffic until rst.
REQ-028 With RAM_IO_RX_EN defined, rx_valid=1, rx_data=0x33, and a read of 0x30000 -> rx_ready pulses once and mem_din=0x33 the next cycle; without the macro, mem_din=0x00 and rx_ready=0.
REQ-029 Assert rst for 1 cycle while the TX queue holds 4 bytes -> tx_valid=0, io_buffer_full=0, and a previously written RAM byte is still readable.

Source files
------------

// File: rtl/ram_io_responder.sv
// ram_io_responder: byte RAM plus memory-mapped TX queue, optional RX port and program-end flag
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   mem_a           controller byte address; bits 17:16 == 2'b11 select IO, else RAM
//   mem_dout        controller write data
//   mem_wr          1 = write, 0 = read
//   mem_din         registered read data, one cycle after the request
//   io_buffer_full  registered: TX queue is within FULL_MARGIN slots of full
//   tx_data         TX queue head byte
//   tx_valid        TX queue non-empty
//   tx_ready        consumer pops the head byte
//   rx_data         input byte
//   rx_valid        rx_data is valid
//   rx_ready        input byte consumed in this cycle
//   prog_end        sticky, set by a write to 0x30004
//   tx_overflow     sticky, set when a TX byte is dropped
//
// Build option: define RAM_IO_RX_EN to enable the RX input path at IO read 0x30000.
module ram_io_responder #(
  parameter int ADDR_W      = 17,
  parameter int TXQ_LOG     = 3,
  parameter int FULL_MARGIN = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_a,
  input  logic [7:0]  mem_dout,
  input  logic        mem_wr,
  output logic [7:0]  mem_din,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        prog_end,
  output logic        tx_overflow
);
  localparam int DEPTH = 1 << TXQ_LOG;
  localparam logic [TXQ_LOG:0] CNT_FULL = (TXQ_LOG+1)'(DEPTH);
  localparam logic [TXQ_LOG:0] CNT_HI = (TXQ_LOG+1)'(DEPTH - FULL_MARGIN);
  localparam logic [TXQ_LOG:0] CNT_ONE = (TXQ_LOG+1)'(1);
  localparam logic [TXQ_LOG-1:0] PTR_ONE = (TXQ_LOG)'(1);

  logic [7:0] ram_q [2**ADDR_W];
  logic [7:0] txq_q [DEPTH];
  logic [ADDR_W-1:0] ram_idx;
  logic is_io, io_tx, io_wr_tx, io_rd_tx, io_wr_end, ram_wr;
  logic rx_take, pop, push;
  logic [7:0] rx_byte;
  logic [TXQ_LOG-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [TXQ_LOG:0] cnt_q, cnt_d;
  logic full_q, full_d, prog_end_q, prog_end_d, ovf_q, ovf_d;
  logic [7:0] mem_din_q, mem_din_d;
  logic unused;

  assign ram_idx   = mem_a[ADDR_W-1:0];
  assign is_io     = mem_a[17:16] == 2'b11;
  assign io_tx     = mem_a[17:0] == 18'h30000;
  assign io_wr_tx  = io_tx && mem_wr;
  assign io_rd_tx  = io_tx && !mem_wr;
  assign io_wr_end = mem_a[17:0] == 18'h30004 && mem_wr;
  assign ram_wr    = !is_io && mem_wr;

`ifdef RAM_IO_RX_EN
  assign rx_take = io_rd_tx && rx_valid;
  assign rx_byte = rx_data;
  assign unused  = ^mem_a[31:18];
`else
  assign rx_take = 1'b0;
  assign rx_byte = 8'h00;
  assign unused  = ^{mem_a[31:18], rx_data, rx_valid, io_rd_tx};
`endif

  // A reset cycle is not an access, so the handshake must not fire.
  assign rx_ready       = rx_take && !rst;
  assign tx_valid       = cnt_q != '0;
  assign tx_data        = txq_q[rd_ptr_q];
  assign io_buffer_full = full_q;
  assign prog_end       = prog_end_q;
  assign tx_overflow    = ovf_q;
  assign mem_din        = mem_din_q;

  always_comb begin
    pop        = tx_valid && tx_ready;
    // A full queue still accepts a byte when the head leaves in the same cycle.
    push       = io_wr_tx && (cnt_q != CNT_FULL || pop);
    wr_ptr_d   = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    cnt_d      = (push && !pop) ? cnt_q + CNT_ONE : (pop && !push) ? cnt_q - CNT_ONE : cnt_q;
    full_d     = cnt_d >= CNT_HI;
    prog_end_d = prog_end_q || io_wr_end;
    ovf_d      = ovf_q || (io_wr_tx && !push);
    mem_din_d  = is_io ? (rx_take ? rx_byte : 8'h00) : mem_wr ? 8'h00 : ram_q[ram_idx];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      full_q     <= 1'b0;
      prog_end_q <= 1'b0;
      ovf_q      <= 1'b0;
      mem_din_q  <= 8'h00;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      full_q     <= full_d;
      prog_end_q <= prog_end_d;
      ovf_q      <= ovf_d;
      mem_din_q  <= mem_din_d;
    end
  end

  // Storage arrays are never cleared; reset only blocks the write.
  always_ff @(posedge clk) begin
    if (!rst && ram_wr) ram_q[ram_idx] <= mem_dout;
  end

  always_ff @(posedge clk) begin
    if (!rst && push) txq_q[wr_ptr_q] <= mem_dout;
  end
endmodule

// File: tb/tb_ram_io_responder.sv
// tb_ram_io_responder: randomized and directed check of ram_io_responder against a queue/array model
module tb_ram_io_responder;
  localparam int QDEPTH = 8;
  localparam int QHI = 6;
`ifdef RAM_IO_RX_EN
  localparam bit RX_EN = 1'b1;
`else
  localparam bit RX_EN = 1'b0;
`endif

  logic clk, rst;
  logic [31:0] mem_a;
  logic [7:0] mem_dout, mem_din, tx_data, rx_data;
  logic mem_wr, io_buffer_full, tx_valid, tx_ready, rx_valid, rx_ready, prog_end, tx_overflow;

  ram_io_responder #(.ADDR_W(17), .TXQ_LOG(3), .FULL_MARGIN(2)) dut (
    .clk(clk), .rst(rst), .mem_a(mem_a), .mem_dout(mem_dout), .mem_wr(mem_wr),
    .mem_din(mem_din), .io_buffer_full(io_buffer_full), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .prog_end(prog_end), .tx_overflow(tx_overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_vec, n_err;
  logic [7:0] ram_m [int];
  logic [7:0] txq_m [$];
  logic pe_m, ov_m, din_ok;
  logic [7:0] din_m;
  logic [17:0] pool [9] = '{18'h00010, 18'h00011, 18'h0ABCD, 18'h1FFFF, 18'h20010,
                            18'h30000, 18'h30000, 18'h30004, 18'h30008};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input logic [31:0] a, input logic [7:0] d, input logic w, input logic tr,
                      input logic [7:0] rd, input logic rv, input logic r);
    logic io, rxr, pop;
    int ai;
    mem_a = a; mem_dout = d; mem_wr = w; tx_ready = tr; rx_data = rd; rx_valid = rv; rst = r;
    #1;
    io  = a[17:16] == 2'b11;
    rxr = !r && RX_EN && io && !w && a[17:0] == 18'h30000 && rv;
    chk("rx_ready", rx_ready, rxr);
    if (r) begin
      txq_m.delete();
      pe_m = 1'b0; ov_m = 1'b0; din_ok = 1'b1; din_m = 8'h00;
    end else begin
      pop = txq_m.size() > 0 && tr;
      if (pop) void'(txq_m.pop_front());
      if (io && w && a[17:0] == 18'h30000) begin
        if (txq_m.size() < QDEPTH) txq_m.push_back(d);
        else ov_m = 1'b1;
      end
      if (io && w && a[17:0] == 18'h30004) pe_m = 1'b1;
      ai = int'(a[16:0]);
      din_ok = 1'b1; din_m = 8'h00;
      if (io) din_m = rxr ? rd : 8'h00;
      else if (w) ram_m[ai] = d;
      else if (ram_m.exists(ai)) din_m = ram_m[ai];
      else din_ok = 1'b0;
    end
    @(posedge clk);
    #1;
    if (din_ok) chk("mem_din", mem_din, din_m);
    chk("tx_valid", tx_valid, txq_m.size() != 0);
    if (txq_m.size() != 0) chk("tx_data", tx_data, txq_m[0]);
    chk("io_buffer_full", io_buffer_full, txq_m.size() >= QHI);
    chk("prog_end", prog_end, pe_m);
    chk("tx_overflow", tx_overflow, ov_m);
  endtask

  initial begin
    logic [31:0] a;
    n_vec = 0; n_err = 0;
    step(32'h0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    step(32'h0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    step(32'h00010, 8'hA5, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    step(32'h00010, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) step(32'h30000, 8'(8'h41 + i), 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    step(32'h30000, 8'h5A, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0);
    step(32'h30000, 8'h49, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    step(32'h30004, 8'h01, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0);
    step(32'h30008, 8'h77, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0);
    step(32'hFFF30000, 8'h00, 1'b0, 1'b0, 8'h33, 1'b1, 1'b0);
    step(32'h30000, 8'h00, 1'b0, 1'b0, 8'h33, 1'b0, 1'b0);
    step(32'h30004, 8'h00, 1'b0, 1'b0, 8'h33, 1'b1, 1'b0);
    step(32'h0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(32'h30000, 8'(8'h60 + i), 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    step(32'h00010, 8'hEE, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    step(32'h00010, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 1500; i++) begin
      a = $urandom;
      a[17:0] = pool[$urandom_range(0, 8)];
      step(a, 8'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0,
           8'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 99) == 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
